smem_bank_ctrl: RTL

One bank of the 16-bank shared memory: owns a 256 x 8 storage array and arbitrates among the 16 cores whose current request maps to this bank. It runs round-robin arbitration, serialises one read or write per grant through a three-state FSM, and returns a one-cycle `finish` pulse with read data to the winning core. The shared-memory top instantiates 16 of these with `BANK_ID` 0..15 and ORs their `data_out`/`finish` buses per core.

---
 rtl/smem_bank_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/smem_bank_ctrl.sv
// -----------------------------------------------------------------------------
// smem_bank_ctrl
//
// One bank of the 16-bank shared memory. It owns a 256 x 8 storage array and
// arbitrates, round-robin, among the cores whose current request maps to this
// bank. Each grant is serialised through IDLE -> ACCESS -> RESP. The winning
// core gets a one-cycle finish pulse, plus its read data on a read.
//
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous, active-low reset
//   read      in   [N_CORES]          per-core read request
//   write     in   [N_CORES]          per-core write request
//   core_val  in   [N_CORES]          per-core request valid
//   addr_in   in   [N_CORES*ADDR_W]   core i address at [ADDR_W*i +: ADDR_W]
//   data_in   in   [N_CORES*DATA_W]   core i write data at [DATA_W*i +: DATA_W]
//   data_out  out  [N_CORES*DATA_W]   core i read data; zero except the served
//                                     slice during a read finish
//   finish    out  [N_CORES]          one-hot completion pulse
//   busy      out                     FSM not in IDLE
// -----------------------------------------------------------------------------
module smem_bank_ctrl #(
  parameter int N_CORES = 16,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int BANK_ID = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_CORES-1:0]          read,
  input  logic [N_CORES-1:0]          write,
  input  logic [N_CORES-1:0]          core_val,
  input  logic [N_CORES*ADDR_W-1:0]   addr_in,
  input  logic [N_CORES*DATA_W-1:0]   data_in,
  output logic [N_CORES*DATA_W-1:0]   data_out,
  output logic [N_CORES-1:0]          finish,
  output logic                        busy
);

  localparam int IDX_W  = $clog2(N_CORES);
  localparam int BANK_W = 4;
  localparam int WORD_W = ADDR_W - BANK_W;
  localparam int DEPTH  = 1 << WORD_W;

  localparam logic [BANK_W-1:0] BANK_SEL = BANK_W'(BANK_ID);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // Per-core request decode
  logic [N_CORES-1:0] eligible;
  logic [WORD_W-1:0]  core_word [N_CORES];
  logic [DATA_W-1:0]  core_data [N_CORES];

  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_core
      logic [ADDR_W-1:0] core_addr;
      assign core_addr     = addr_in[gi*ADDR_W +: ADDR_W];
      // A request with both read and write set is malformed and never wins.
      assign eligible[gi]  = core_val[gi] & (read[gi] ^ write[gi]) &
                             (core_addr[BANK_W-1:0] == BANK_SEL);
      assign core_word[gi] = core_addr[ADDR_W-1:BANK_W];
      assign core_data[gi] = data_in[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Transaction state
  logic [1:0]         state_reg;
  logic [IDX_W-1:0]   rr_reg;
  logic [IDX_W-1:0]   grant_reg;
  logic               op_write_reg;
  logic [WORD_W-1:0]  word_reg;
  logic [DATA_W-1:0]  wdata_reg;
  logic [N_CORES-1:0] finish_reg;
  logic [DATA_W-1:0]  rdata_reg;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Round-robin pick: scan from the farthest offset down to offset 0 so that
  // the last hit, i.e. the one closest to rr_reg, is the one that sticks.
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    grant_next = rr_reg;
    scan_idx   = rr_reg;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      scan_idx = rr_reg + IDX_W'(k);
      if (eligible[scan_idx]) begin
        grant_next = scan_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rr_reg       <= '0;
      grant_reg    <= '0;
      op_write_reg <= 1'b0;
      word_reg     <= '0;
      wdata_reg    <= '0;
      finish_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            // Everything the access needs is captured here, so the requester
            // may change its inputs after the grant without effect.
            grant_reg    <= grant_next;
            op_write_reg <= write[grant_next];
            word_reg     <= core_word[grant_next];
            wdata_reg    <= core_data[grant_next];
            rr_reg       <= grant_next + 1'b1;
            state_reg    <= ACCESS;
          end
        end
        ACCESS: begin
          finish_reg <= N_CORES'(1) << grant_reg;
          state_reg  <= RESP;
        end
        RESP: begin
          finish_reg <= '0;
          state_reg  <= IDLE;
        end
        default: begin
          finish_reg <= '0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  // Storage port. Not reset: contents are undefined until written. A reset
  // during ACCESS forces state_reg back to IDLE before the edge, so an aborted
  // write never reaches the array.
  always_ff @(posedge clock) begin
    if (state_reg == ACCESS) begin
      if (op_write_reg) begin
        mem[word_reg] <= wdata_reg;
      end
      rdata_reg <= mem[word_reg];
    end
  end

  // Read data is only presented while the winner's finish pulse is high; the
  // reset of finish_reg therefore also clears data_out.
  generate
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_dout
      assign data_out[gi*DATA_W +: DATA_W] =
        (finish_reg[gi] && !op_write_reg) ? rdata_reg : '0;
    end
  endgenerate

  assign finish = finish_reg;
  assign busy   = (state_reg != IDLE);

endmodule
